// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the 3x3 fuzzy inference back end.
// Q1.15 membership/strength type, percent type, unity constant and default rule table.
// Pure declarations; no logic.
package fuzzy_pkg;

  typedef logic [15:0] q15_t;
  typedef logic [7:0]  pct_t;

  localparam q15_t        Q15_ONE = 16'h8000;
  localparam int unsigned PCT_MAX = 100;

  // Default rule output levels: row = T term (neg, zero, pos), column = D term.
  localparam pct_t DEF_G [3][3] = '{
    '{8'd100, 8'd80, 8'd60},
    '{8'd70,  8'd50, 8'd30},
    '{8'd40,  8'd20, 8'd0 }
  };

endpackage

// File: rtl/fuzzy_defuzz_reg.sv
// Defuzzifier: normalise weighted level by strength (floor 1.0), clamp, register.
// Latency: 1 cycle from S_w/S_wg to G_out; divider is combinational.
// No backpressure: output continuously valid, updated every clock.
module fuzzy_defuzz_reg #(
  parameter int unsigned PCT_MAX = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_s_w,
  input  logic [15:0] i_s_wg,
  output logic [7:0]  o_g
);
  import fuzzy_pkg::*;

  q15_t        w_den;
  logic [30:0] w_num;
  logic [30:0] w_q;
  pct_t        w_g_next;
  pct_t        r_g;

  // Denominator never drops below 1.0, so small total strength passes S_wg through and
  // division by zero cannot occur.
  always_comb begin
    w_den    = (i_s_w < Q15_ONE) ? Q15_ONE : i_s_w;
    w_num    = {i_s_wg, 15'd0};
    w_q      = w_num / {15'd0, w_den};
    w_g_next = (w_q > 31'(PCT_MAX)) ? 8'(PCT_MAX) : w_q[7:0];
  end

  // Crisp output register; reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_g <= '0;
    else        r_g <= w_g_next;
  end

  assign o_g = r_g;

endmodule

// File: rtl/fuzzy_infer_core.sv
// 3x3 min-rule fuzzy inference: firing strengths, weighted aggregation, registered defuzz.
// Latency: S_w/S_wg combinational; G_out 1 cycle after any input change.
// No handshake; all outputs continuously valid.
module fuzzy_infer_core #(
  parameter int unsigned PCT_MAX = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] muT_neg,
  input  logic [15:0] muT_zero,
  input  logic [15:0] muT_pos,
  input  logic [15:0] muD_neg,
  input  logic [15:0] muD_zero,
  input  logic [15:0] muD_pos,
  input  logic        reg_mode,
  input  logic [7:0]  g00,
  input  logic [7:0]  g01,
  input  logic [7:0]  g02,
  input  logic [7:0]  g10,
  input  logic [7:0]  g11,
  input  logic [7:0]  g12,
  input  logic [7:0]  g20,
  input  logic [7:0]  g21,
  input  logic [7:0]  g22,
  output logic [15:0] S_w,
  output logic [15:0] S_wg,
  output logic [7:0]  G_out
);
  import fuzzy_pkg::*;

  q15_t        w_mu_t [3];
  q15_t        w_mu_d [3];
  pct_t        w_g    [3][3];
  q15_t        w_str  [3][3];
  pct_t        w_gsel [3][3];
  logic [19:0] w_sum_w;
  logic [19:0] w_sum_wg;

  assign w_mu_t = '{muT_neg, muT_zero, muT_pos};
  assign w_mu_d = '{muD_neg, muD_zero, muD_pos};
  assign w_g    = '{'{g00, g01, g02}, '{g10, g11, g12}, '{g20, g21, g22}};

  // Rule matrix: strength is the min of the two antecedents; level from inputs or default table.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_str[i][j]  = (w_mu_t[i] < w_mu_d[j]) ? w_mu_t[i] : w_mu_d[j];
        w_gsel[i][j] = reg_mode ? w_g[i][j] : DEF_G[i][j];
      end
    end
  end

  // Aggregation in 20 bits; each weighted product is truncated to integer percent before summing.
  always_comb begin
    w_sum_w  = '0;
    w_sum_wg = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_sum_w  = w_sum_w + 20'(w_str[i][j]);
        w_sum_wg = w_sum_wg + 20'((32'(w_str[i][j]) * 32'(w_gsel[i][j])) >> 15);
      end
    end
  end

  assign S_w  = (w_sum_w  > 20'h0FFFF) ? 16'hFFFF : w_sum_w[15:0];
  assign S_wg = (w_sum_wg > 20'h0FFFF) ? 16'hFFFF : w_sum_wg[15:0];

  fuzzy_defuzz_reg #(
    .PCT_MAX (PCT_MAX)
  ) u_defuzz (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_s_w  (S_w),
    .i_s_wg (S_wg),
    .o_g    (G_out)
  );

endmodule

// File: tb/tb_fuzzy_infer_core.sv
// Directed bench for fuzzy_infer_core with hand-computed expectations.
module tb_fuzzy_infer_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] muT_neg, muT_zero, muT_pos;
  logic [15:0] muD_neg, muD_zero, muD_pos;
  logic        reg_mode;
  logic [7:0]  g00, g01, g02, g10, g11, g12, g20, g21, g22;
  logic [15:0] S_w, S_wg;
  logic [7:0]  G_out;

  int errors = 0;
  int checks = 0;

  fuzzy_infer_core #(.PCT_MAX(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .muT_neg(muT_neg), .muT_zero(muT_zero), .muT_pos(muT_pos),
    .muD_neg(muD_neg), .muD_zero(muD_zero), .muD_pos(muD_pos),
    .reg_mode(reg_mode),
    .g00(g00), .g01(g01), .g02(g02),
    .g10(g10), .g11(g11), .g12(g12),
    .g20(g20), .g21(g21), .g22(g22),
    .S_w(S_w), .S_wg(S_wg), .G_out(G_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (time %0t)", $time);
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    muT_neg = 0; muT_zero = 0; muT_pos = 0;
    muD_neg = 0; muD_zero = 0; muD_pos = 0;
    reg_mode = 1'b1;
    g00 = 0; g01 = 0; g02 = 0; g10 = 0; g11 = 0; g12 = 0; g20 = 0; g21 = 0; g22 = 0;
  endtask

  task automatic set_single_rule();
    clear_inputs();
    muT_pos = 16'h4000; muD_pos = 16'h4000; g22 = 8'd100;
  endtask

  task automatic test_reset();
    set_single_rule();
    rst_n = 1'b0;
    #1;
    checks++;
    if (G_out !== 8'd0) begin
      $display("FAIL reset_initial: G_out got %0d expected 0", G_out); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd0) begin
      $display("FAIL reset_held: G_out got %0d expected 0", G_out); errors++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd50) begin
      $display("FAIL reset_release_load: G_out got %0d expected 50", G_out); errors++;
    end
    // Mid-cycle reset drops G_out without waiting for a clock edge.
    #2; rst_n = 1'b0; #1;
    checks++;
    if (G_out !== 8'd0) begin
      $display("FAIL reset_async: G_out got %0d expected 0", G_out); errors++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd50) begin
      $display("FAIL reset_reload: G_out got %0d expected 50", G_out); errors++;
    end
  endtask

  task automatic test_single_rule();
    @(negedge clk);
    set_single_rule();
    #1;
    checks++;
    if (S_w !== 16'h4000) begin
      $display("FAIL single_sw: S_w got %h expected 4000", S_w); errors++;
    end
    checks++;
    if (S_wg !== 16'd50) begin
      $display("FAIL single_swg: S_wg got %0d expected 50", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd50) begin
      $display("FAIL single_g: G_out got %0d expected 50", G_out); errors++;
    end
  endtask

  task automatic test_overlap();
    @(negedge clk);
    clear_inputs();
    muT_zero = 16'h4000; muT_pos = 16'h4000; muD_zero = 16'h4000; muD_pos = 16'h4000;
    g11 = 8'd30; g22 = 8'd80;
    #1;
    checks++;
    if (S_w !== 16'hFFFF) begin
      $display("FAIL overlap_sw: S_w got %h expected ffff", S_w); errors++;
    end
    checks++;
    if (S_wg !== 16'd55) begin
      $display("FAIL overlap_swg: S_wg got %0d expected 55", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd27) begin
      $display("FAIL overlap_g: G_out got %0d expected 27", G_out); errors++;
    end
  endtask

  task automatic test_saturation_clamp();
    @(negedge clk);
    clear_inputs();
    muT_neg = 16'h7FFF; muT_zero = 16'h7FFF; muT_pos = 16'h7FFF;
    muD_neg = 16'h7FFF; muD_zero = 16'h7FFF; muD_pos = 16'h7FFF;
    g00 = 100; g01 = 100; g02 = 100; g10 = 100; g11 = 100;
    g12 = 100; g20 = 100; g21 = 100; g22 = 100;
    #1;
    checks++;
    if (S_w !== 16'hFFFF) begin
      $display("FAIL sat_sw: S_w got %h expected ffff", S_w); errors++;
    end
    checks++;
    if (S_wg !== 16'd891) begin
      $display("FAIL sat_swg: S_wg got %0d expected 891", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd100) begin
      $display("FAIL sat_clamp_g: G_out got %0d expected 100", G_out); errors++;
    end
  endtask

  task automatic test_default_table();
    @(negedge clk);
    clear_inputs();
    reg_mode = 1'b0;
    muT_zero = 16'h7FFF; muD_zero = 16'h7FFF;
    g11 = 8'd7; g00 = 8'd200; g22 = 8'd13;
    #1;
    checks++;
    if (S_w !== 16'h7FFF) begin
      $display("FAIL default_sw: S_w got %h expected 7fff", S_w); errors++;
    end
    checks++;
    if (S_wg !== 16'd49) begin
      $display("FAIL default_swg: S_wg got %0d expected 49", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd49) begin
      $display("FAIL default_g: G_out got %0d expected 49", G_out); errors++;
    end
    // Default table corner entry: T neg / D neg = 100.
    @(negedge clk);
    muT_zero = 0; muD_zero = 0; muT_neg = 16'h4000; muD_neg = 16'h6000;
    #1;
    checks++;
    if (S_wg !== 16'd50) begin
      $display("FAIL default_corner_swg: S_wg got %0d expected 50", S_wg); errors++;
    end
  endtask

  task automatic test_min_zero();
    @(negedge clk);
    clear_inputs();
    reg_mode = 1'b0;
    muT_neg = 16'h2000; muD_pos = 16'h6000;
    #1;
    checks++;
    if (S_w !== 16'h2000) begin
      $display("FAIL min_sw: S_w got %h expected 2000", S_w); errors++;
    end
    // w02 = 0x2000 with default level 60 -> 15
    checks++;
    if (S_wg !== 16'd15) begin
      $display("FAIL min_swg: S_wg got %0d expected 15", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd15) begin
      $display("FAIL min_g: G_out got %0d expected 15", G_out); errors++;
    end
    @(negedge clk);
    clear_inputs();
    g00 = 100; g11 = 100; g22 = 100;
    #1;
    checks++;
    if (S_w !== 16'h0000) begin
      $display("FAIL zero_sw: S_w got %h expected 0000", S_w); errors++;
    end
    checks++;
    if (S_wg !== 16'd0) begin
      $display("FAIL zero_swg: S_wg got %0d expected 0", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd0) begin
      $display("FAIL zero_g: G_out got %0d expected 0", G_out); errors++;
    end
  endtask

  task automatic test_large_g();
    // Level above 100 is used as given: 0x2000 * 240 >> 15 = 60.
    @(negedge clk);
    clear_inputs();
    muT_neg = 16'h2000; muD_neg = 16'h2000; g00 = 8'd240;
    #1;
    checks++;
    if (S_wg !== 16'd60) begin
      $display("FAIL large_g_swg: S_wg got %0d expected 60", S_wg); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd60) begin
      $display("FAIL large_g_g: G_out got %0d expected 60", G_out); errors++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_single_rule();
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd50) begin
      $display("FAIL b2b_first: G_out got %0d expected 50", G_out); errors++;
    end
    @(negedge clk);
    clear_inputs();
    reg_mode = 1'b0; muT_zero = 16'h7FFF; muD_zero = 16'h7FFF;
    #1;
    checks++;
    if (G_out !== 8'd50) begin
      $display("FAIL b2b_hold: G_out got %0d expected 50", G_out); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd49) begin
      $display("FAIL b2b_second: G_out got %0d expected 49", G_out); errors++;
    end
    // Strength exactly 1.0: den = 0x8000, q = S_wg = 100 * 0x8000 >> 15 = 100.
    @(negedge clk);
    clear_inputs();
    muT_pos = 16'h8000; muD_neg = 16'h8000; g20 = 8'd100;
    @(posedge clk); #1;
    checks++;
    if (G_out !== 8'd100) begin
      $display("FAIL b2b_unity: G_out got %0d expected 100", G_out); errors++;
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_rule();
    test_overlap();
    test_saturation_clamp();
    test_default_table();
    test_min_zero();
    test_large_g();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
